pmp_unit: RTL and testbench

PMP_UNIT -- requirements
Module: pmp_unit

---
 rtl/pmp_pkg.sv | 23 ++
 rtl/pmp_match.sv | 58 +++++
 rtl/pmp_unit.sv | 103 ++++++++++
 tb/tb_pmp_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - shared PMP types, widths and field encodings
package pmp_pkg;

    localparam int PAB = 54;

    typedef logic [63:0] word64;
    typedef logic [PAB:0] pmpaddr_type;
    typedef pmpaddr_type [15:0] pmpaddr_vec_type;

    localparam logic [1:0] A_OFF   = 2'b00;
    localparam logic [1:0] A_TOR   = 2'b01;
    localparam logic [1:0] A_NA4   = 2'b10;
    localparam logic [1:0] A_NAPOT = 2'b11;

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_S = 2'b01;
    localparam logic [1:0] PRV_M = 2'b11;

    localparam logic [1:0] ACC_X = 2'b00;
    localparam logic [1:0] ACC_R = 2'b01;
    localparam logic [1:0] ACC_W = 2'b11;

endpackage

// File: rtl/pmp_match.sv
// rtl/pmp_match.sv - address match for one PMP entry (TOR / NA4 / NAPOT)
module pmp_match
    import pmp_pkg::*;
#(
    parameter int pmp_g  = 10,
    parameter int pab    = 54,
    parameter int no_tor = 0
) (
    input  logic [1:0]     i_mode,
    input  logic [pab-1:0] i_addr,
    input  logic [pab-1:0] i_pmpaddr,
    input  logic [pab-1:0] i_lower,
    output logic           o_match
);

    logic [pab-1:0] w_napot_addr;
    logic [pab-1:0] w_gran_mask;
    logic [pab-1:0] w_napot_mask;
    logic [pab-1:0] w_tor_lo;
    logic [pab-1:0] w_tor_hi;
    logic [pab-1:0] w_tor_ad;
    logic           w_napot_hit;
    logic           w_na4_hit;
    logic           w_tor_hit;

    // Granularity: NAPOT low bits read as ones, TOR ignores bits below G
    always_comb begin
        w_napot_addr = i_pmpaddr;
        w_gran_mask  = '0;
        for (int b = 0; b < pab; b++) begin
            if (b + 2 <= pmp_g) w_napot_addr[b] = 1'b1;
            if (b >= pmp_g)     w_gran_mask[b]  = 1'b1;
        end
    end

    // pmpaddr ^ (pmpaddr+1) sets the trailing ones plus the lowest zero bit;
    // only the bits above that are compared
    assign w_napot_mask = ~(w_napot_addr ^ (w_napot_addr + pab'(1)));
    assign w_napot_hit  = ((i_addr ^ w_napot_addr) & w_napot_mask) == '0;
    assign w_na4_hit    = (pmp_g == 0) && (i_addr == i_pmpaddr);

    assign w_tor_lo  = i_lower & w_gran_mask;
    assign w_tor_hi  = i_pmpaddr & w_gran_mask;
    assign w_tor_ad  = i_addr & w_gran_mask;
    assign w_tor_hit = (no_tor == 0) && (w_tor_lo <= w_tor_ad) && (w_tor_ad < w_tor_hi);

    // Select the hit for the entry's address-matching mode
    always_comb begin
        o_match = 1'b0;
        case (i_mode)
            A_TOR:   o_match = w_tor_hit;
            A_NA4:   o_match = w_na4_hit;
            A_NAPOT: o_match = w_napot_hit;
            default: o_match = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_unit.sv
// rtl/pmp_unit.sv - PMP access check with one-cycle registered grant
module pmp_unit
    import pmp_pkg::*;
#(
    parameter int pmp_check   = 1,
    parameter int pmp_no_tor  = 0,
    parameter int pmp_entries = 16,
    parameter int pmp_g       = 10,
    parameter int pmp_msb     = 55
) (
    input  logic                                  clk300p,
    input  logic                                  rstn,
    input  logic [pmp_entries-1:0][pmp_msb-1:0]   pmpaddr,
    input  logic [63:0]                           pmpcfg0,
    input  logic [63:0]                           pmpcfg2,
    input  logic [pmp_msb:0]                      address,
    input  logic [1:0]                            acc,
    input  logic [1:0]                            prv,
    input  logic                                  mprv,
    input  logic [1:0]                            mpp,
    input  logic                                  valid,
    output logic                                  ok
);

    localparam int PAB_L = pmp_msb - 1;

    logic [15:0][7:0]       w_cfg;
    logic [PAB_L-1:0]       w_addr;
    logic [pmp_entries-1:0] w_match;
    logic [pmp_entries-1:0] w_carry;
    logic                   w_hit;
    logic                   w_lock;
    logic                   w_perm;
    logic [1:0]             w_eff_prv;
    logic                   w_grant;
    logic                   w_unused;
    logic                   r_ok;

    assign w_cfg  = {pmpcfg2, pmpcfg0};
    assign w_addr = address[pmp_msb:2];

    for (genvar gi = 0; gi < pmp_entries; gi++) begin : g_entry
        logic [PAB_L-1:0] w_lower;
        if (gi == 0) begin : g_first
            assign w_lower = '0;
        end else begin : g_rest
            assign w_lower = pmpaddr[gi-1][PAB_L-1:0];
        end
        assign w_carry[gi] = pmpaddr[gi][PAB_L];

        pmp_match #(
            .pmp_g  (pmp_g),
            .pab    (PAB_L),
            .no_tor (pmp_no_tor)
        ) u_match (
            .i_mode    (w_cfg[gi][4:3]),
            .i_addr    (w_addr),
            .i_pmpaddr (pmpaddr[gi][PAB_L-1:0]),
            .i_lower   (w_lower),
            .o_match   (w_match[gi])
        );
    end

    // Lowest-numbered matching entry wins: scan downward so it assigns last
    always_comb begin
        w_hit  = 1'b0;
        w_lock = 1'b0;
        w_perm = 1'b0;
        for (int i = pmp_entries - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit  = 1'b1;
                w_lock = w_cfg[i][7];
                case (acc)
                    ACC_X:   w_perm = w_cfg[i][2];
                    ACC_W:   w_perm = w_cfg[i][1];
                    ACC_R:   w_perm = w_cfg[i][0];
                    default: w_perm = w_cfg[i][0];
                endcase
            end
        end
    end

    // MPRV redirects data accesses in M mode to MPP's privilege
    assign w_eff_prv = (prv == PRV_M && mprv && acc != ACC_X) ? mpp : prv;
    assign w_grant   = (w_eff_prv == PRV_M) ? (!(w_hit && w_lock) || w_perm)
                                            : (w_hit && w_perm);

    // Inputs that never influence the result (valid, byte offset, carry bits,
    // reserved cfg bits) are folded into a constant-zero term
    assign w_unused = ^{valid, address[1:0], w_carry, w_cfg};

    // Result register; reset discards whatever was in flight
    always_ff @(posedge clk300p or negedge rstn) begin
        if (!rstn) begin
            r_ok <= 1'b0;
        end else begin
            r_ok <= ((pmp_check == 0) ? 1'b1 : w_grant) | (w_unused & 1'b0);
        end
    end

    assign ok = r_ok;

endmodule

// File: tb/tb_pmp_unit.sv
// tb/tb_pmp_unit.sv - self-checking bench for pmp_unit
module tb_pmp_unit;

    typedef struct {
        logic [63:0] cfg0;
        logic [63:0] cfg2;
        logic [54:0] a0;
        logic [54:0] a1;
        logic [54:0] a15;
        logic [55:0] addr;
        logic [1:0]  acc;
        logic [1:0]  prv;
        logic        mprv;
        logic [1:0]  mpp;
        logic        exp;
    } vec_t;

    logic              clk300p = 1'b0;
    logic              rstn;
    logic [15:0][54:0] pmpaddr;
    logic [63:0]       pmpcfg0;
    logic [63:0]       pmpcfg2;
    logic [55:0]       address;
    logic [1:0]        acc;
    logic [1:0]        prv;
    logic              mprv;
    logic [1:0]        mpp;
    logic              valid;
    logic              ok;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];
    logic exp_q[$];
    int   id_q[$];

    pmp_unit dut (
        .clk300p (clk300p),
        .rstn    (rstn),
        .pmpaddr (pmpaddr),
        .pmpcfg0 (pmpcfg0),
        .pmpcfg2 (pmpcfg2),
        .address (address),
        .acc     (acc),
        .prv     (prv),
        .mprv    (mprv),
        .mpp     (mpp),
        .valid   (valid),
        .ok      (ok)
    );

    always #5 clk300p = ~clk300p;

    function automatic vec_t mk(logic [63:0] cfg0, logic [54:0] a0, logic [54:0] a1,
                                logic [55:0] addr, logic [1:0] acc_i, logic [1:0] prv_i,
                                logic mprv_i, logic [1:0] mpp_i, logic exp);
        vec_t v;
        v.cfg0 = cfg0; v.cfg2 = 64'h0; v.a0 = a0; v.a1 = a1; v.a15 = 55'h0;
        v.addr = addr; v.acc = acc_i; v.prv = prv_i; v.mprv = mprv_i; v.mpp = mpp_i;
        v.exp = exp;
        return v;
    endfunction

    task automatic set_inputs(vec_t v);
        pmpaddr     = '0;
        pmpaddr[0]  = v.a0;
        pmpaddr[1]  = v.a1;
        pmpaddr[15] = v.a15;
        pmpcfg0 = v.cfg0;
        pmpcfg2 = v.cfg2;
        address = v.addr;
        acc = v.acc; prv = v.prv; mprv = v.mprv; mpp = v.mpp;
    endtask

    task automatic check(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: ok=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v, int id);
        @(negedge clk300p);
        set_inputs(v);
        valid = id[0];
        exp_q.push_back(v.exp);
        id_q.push_back(id);
        @(posedge clk300p);
        #1;
        begin
            logic e;
            int   k;
            e = exp_q.pop_front();
            k = id_q.pop_front();
            check($sformatf("vec%0d", k), ok, e);
        end
    endtask

    localparam logic [1:0] U = 2'b00, S = 2'b01, M = 2'b11;
    localparam logic [1:0] X = 2'b00, R = 2'b01, W = 2'b11;

    initial begin
        vec_t v;
        vec_t g1;

        vecs.push_back(mk(64'h1B,   55'h1FFFF,  0, 56'h100,    R, U, 0, U, 1));
        vecs.push_back(mk(64'h1B,   55'h1FFFF,  0, 56'h100,    X, U, 0, U, 0));
        vecs.push_back(mk(64'h0,    0,          0, 56'h12345678, W, M, 0, U, 1));
        vecs.push_back(mk(64'h0,    0,          0, 56'h12345678, W, S, 0, U, 0));
        vecs.push_back(mk(64'h09,   55'h100000, 0, 56'h3FF000, R, U, 0, U, 1));
        vecs.push_back(mk(64'h09,   55'h100000, 0, 56'h400000, R, U, 0, U, 0));
        vecs.push_back(mk(64'h09,   55'h100000, 0, 56'h3FF000, W, U, 0, U, 0));
        vecs.push_back(mk(64'h09,   55'h100000, 0, 56'h3FF000, 2'b10, U, 0, U, 1));
        vecs.push_back(mk(64'h98,   55'h1FFFF,  0, 56'h100,    R, M, 0, U, 0));
        vecs.push_back(mk(64'h18,   55'h1FFFF,  0, 56'h100,    R, M, 0, U, 1));
        vecs.push_back(mk(64'h0,    0,          0, 56'h100,    R, M, 1, U, 0));
        vecs.push_back(mk(64'h0,    0,          0, 56'h100,    X, M, 1, U, 1));
        vecs.push_back(mk(64'h1F18, 55'h1FFFF, 55'h3FFFF, 56'h100, R, U, 0, U, 0));
        vecs.push_back(mk(64'h1F00, 55'h1FFFF, 55'h3FFFF, 56'h100, R, U, 0, U, 1));
        vecs.push_back(mk(64'h1B,   0,          0, 56'hFFC,    R, U, 0, U, 1));
        vecs.push_back(mk(64'h1B,   0,          0, 56'h1000,   R, U, 0, U, 0));
        vecs.push_back(mk(64'h13,   55'h40,     0, 56'h100,    R, U, 0, U, 0));
        vecs.push_back(mk(64'h1B,   55'h40_0000_0001_FFFF, 0, 56'h100, R, U, 0, U, 1));
        v = mk(64'h0, 0, 0, 56'h100, R, U, 0, U, 1);
        v.cfg2 = 64'h1B00_0000_0000_0000;
        v.a15  = 55'h1FFFF;
        vecs.push_back(v);
        vecs.push_back(mk(64'h89,   55'h100000, 0, 56'h3FF000, R, M, 0, U, 1));
        vecs.push_back(mk(64'h89,   55'h100000, 0, 56'h3FF000, W, M, 0, U, 0));
        vecs.push_back(mk(64'h19,   55'h1FFFF,  0, 56'h100,    W, M, 1, U, 0));
        vecs.push_back(mk(64'h19,   55'h1FFFF,  0, 56'h100,    X, M, 1, U, 1));
        vecs.push_back(mk(64'h0900, 55'h1000, 55'h2000, 56'h4000, R, U, 0, U, 1));
        vecs.push_back(mk(64'h0900, 55'h1000, 55'h2000, 56'h3FFC, R, U, 0, U, 0));
        vecs.push_back(mk(64'h0900, 55'h2000, 55'h1000, 56'h4000, R, U, 0, U, 0));

        g1 = mk(64'h0, 0, 0, 56'h100, W, M, 0, U, 1);

        rstn  = 1'b0;
        valid = 1'b1;
        set_inputs(g1);
        #1;
        check("reset_ok", ok, 1'b0);
        @(posedge clk300p);
        @(posedge clk300p);
        #1;
        check("reset_held", ok, 1'b0);
        @(negedge clk300p);
        rstn = 1'b1;
        #1;
        check("before_first_edge", ok, 1'b0);
        @(posedge clk300p);
        #1;
        check("first_eval", ok, 1'b1);

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], i);

        drive(g1, 100);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset", ok, 1'b0);
        @(posedge clk300p);
        #1;
        check("reset_mid_op", ok, 1'b0);
        @(negedge clk300p);
        rstn = 1'b1;
        @(posedge clk300p);
        #1;
        check("after_reset", ok, 1'b1);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
